// File: rtl/clock_time_setter.sv
// clock_time_setter: 24-hour HH:MM:SS timekeeper with debounced MODE/INC set controls.
// Drives registered BCD digits, a blink-blank mask and the seconds LSB to the display stage.
module clock_time_setter #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int DEB_W = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] seg3,
    output logic [3:0] seg2,
    output logic [3:0] seg1,
    output logic [3:0] seg0,
    output logic [3:0] blank,
    output logic       sec_odd,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} mode_e;
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);
    logic [1:0] btn_raw, press;
    assign btn_raw = {btn_inc, btn_mode};
    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic [1:0] sync_q;
        logic [DEB_W-1:0] cnt_q, cnt_d;
        logic level_q, level_d, press_q, press_d, settled;
        always_comb begin
            settled = sync_q[1] != level_q && cnt_q == DEB_MAX;
            cnt_d = (sync_q[1] == level_q || settled) ? '0 : cnt_q + 1'b1;
            level_d = level_q ^ settled;
            press_d = settled & ~level_q;
        end
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
                cnt_q <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[0], btn_raw[b]};
                cnt_q <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
            end
        end
        assign press[b] = press_q;
    end
    mode_e mode_q, mode_d;
    logic blink_q, blink_d;
    logic [5:0] sec_q, sec_d;
    logic [3:0] ht_q, ho_q, mt_q, mo_q, ht_d, ho_d, mt_d, mo_d, blank_q, blank_d;
    logic [3:0] ht_inc, ho_inc, mt_inc, mo_inc;
    logic mode_press, inc_press, sec_wrap, min_wrap, hr_wrap;
    // MODE has priority: a coincident INC press is dropped
    assign mode_press = press[0];
    assign inc_press = press[1] & ~press[0];
    assign sec_wrap = sec_q == 6'd59;
    assign min_wrap = mt_q == 4'd5 && mo_q == 4'd9;
    assign hr_wrap = ht_q == 4'd2 && ho_q == 4'd3;
    assign mo_inc = mo_q == 4'd9 ? 4'd0 : mo_q + 4'd1;
    assign mt_inc = mo_q != 4'd9 ? mt_q : mt_q == 4'd5 ? 4'd0 : mt_q + 4'd1;
    assign ho_inc = (hr_wrap || ho_q == 4'd9) ? 4'd0 : ho_q + 4'd1;
    assign ht_inc = hr_wrap ? 4'd0 : ho_q == 4'd9 ? ht_q + 4'd1 : ht_q;
    always_comb begin
        mode_d = mode_q;
        blink_d = blink_q;
        sec_d = sec_q;
        ht_d = ht_q;
        ho_d = ho_q;
        mt_d = mt_q;
        mo_d = mo_q;
        case (mode_q)
            RUN: begin
                if (tick_1hz) begin
                    sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
                    if (sec_wrap) begin
                        mt_d = mt_inc;
                        mo_d = mo_inc;
                    end
                    if (sec_wrap && min_wrap) begin
                        ht_d = ht_inc;
                        ho_d = ho_inc;
                    end
                end
                if (mode_press) begin
                    mode_d = SET_HOUR;
                    blink_d = 1'b0;
                end
            end
            SET_HOUR: begin
                mode_d = mode_press ? SET_MIN : SET_HOUR;
                blink_d = mode_press ? 1'b0 : blink_q ^ tick_1hz;
                if (inc_press) begin
                    ht_d = ht_inc;
                    ho_d = ho_inc;
                end
            end
            SET_MIN: begin
                mode_d = mode_press ? RUN : SET_MIN;
                blink_d = mode_press ? 1'b0 : blink_q ^ tick_1hz;
                if (mode_press) sec_d = 6'd0;
                if (inc_press) begin
                    mt_d = mt_inc;
                    mo_d = mo_inc;
                end
            end
            default: begin
                mode_d = RUN;
                blink_d = 1'b0;
            end
        endcase
        blank_d = !blink_d ? 4'b0000 : mode_d == SET_HOUR ? 4'b1100 : mode_d == SET_MIN ? 4'b0011 : 4'b0000;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q <= RUN;
            blink_q <= 1'b0;
            sec_q <= '0;
            ht_q <= '0;
            ho_q <= '0;
            mt_q <= '0;
            mo_q <= '0;
            blank_q <= '0;
        end else begin
            mode_q <= mode_d;
            blink_q <= blink_d;
            sec_q <= sec_d;
            ht_q <= ht_d;
            ho_q <= ho_d;
            mt_q <= mt_d;
            mo_q <= mo_d;
            blank_q <= blank_d;
        end
    end
    assign seg3 = ht_q;
    assign seg2 = ho_q;
    assign seg1 = mt_q;
    assign seg0 = mo_q;
    assign blank = blank_q;
    assign sec_odd = sec_q[0];
    assign mode = mode_q;
endmodule

// File: tb/tb_clock_time_setter.sv
// tb_clock_time_setter: random and directed stimulus against a seconds/minutes/hours reference model.
module tb_clock_time_setter;
    localparam int N = 4;
    logic clock = 1'b0, reset = 1'b1, tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [3:0] seg3, seg2, seg1, seg0, blank;
    logic sec_odd;
    logic [1:0] mode;
    logic [22:0] got;
    int checks = 0, failures = 0;
    logic [22:0] exp_q[$];
    int h, m, s, md;
    bit blk, deb_m, deb_i, pend_m, pend_i;
    bit hm[$], hi[$];

    always #5 clock = ~clock;

    clock_time_setter #(.DEBOUNCE_CYCLES(N), .DEB_W(3)) dut (
        .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0), .blank(blank), .sec_odd(sec_odd), .mode(mode)
    );

    assign got = {seg3, seg2, seg1, seg0, blank, sec_odd, mode};

    task automatic check(input string name, input logic [22:0] g, input logic [22:0] e);
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL %s at %0t: got digits=%h blank=%b sec_odd=%b mode=%b, required digits=%h blank=%b sec_odd=%b mode=%b",
                     name, $time, g[22:7], g[6:3], g[2], g[1:0], e[22:7], e[6:3], e[2], e[1:0]);
        end
    endtask

    always @(negedge clock) if (exp_q.size() != 0) check("outputs", got, exp_q.pop_front());

    // A level flips once the last N synchronised samples (two cycles old) all disagree with it
    function automatic bit all_diff(input bit q[$], input bit lvl);
        for (int j = 0; j < N; j++) if (q[q.size() - 3 - j] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [22:0] expected();
        logic [3:0] bl;
        bl = !blk ? 4'b0000 : md == 1 ? 4'b1100 : md == 2 ? 4'b0011 : 4'b0000;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), bl, 1'(s % 2), 2'(md)};
    endfunction

    task automatic model(input bit t, input bit bm, input bit bi, input bit r);
        bit mp, ip, fm, fi;
        if (r) begin
            h = 0; m = 0; s = 0; md = 0; blk = 0;
            deb_m = 0; deb_i = 0; pend_m = 0; pend_i = 0;
            hm.delete(); hi.delete();
            repeat (N + 2) begin hm.push_back(1'b0); hi.push_back(1'b0); end
        end else begin
            mp = pend_m;
            ip = pend_i && !mp;
            if (md == 0) begin
                if (t) begin
                    s++;
                    if (s == 60) begin
                        s = 0; m++;
                        if (m == 60) begin m = 0; h = (h + 1) % 24; end
                    end
                end
                if (mp) begin md = 1; blk = 0; end
            end else if (mp) begin
                md = (md == 1) ? 2 : 0;
                blk = 0;
                if (md == 0) s = 0;
            end else begin
                blk ^= t;
                if (ip && md == 1) h = (h + 1) % 24;
                if (ip && md == 2) m = (m + 1) % 60;
            end
            hm.push_back(bm);
            hi.push_back(bi);
            fm = all_diff(hm, deb_m);
            fi = all_diff(hi, deb_i);
            pend_m = fm && !deb_m;
            pend_i = fi && !deb_i;
            deb_m ^= fm;
            deb_i ^= fi;
            while (hm.size() > N + 3) void'(hm.pop_front());
            while (hi.size() > N + 3) void'(hi.pop_front());
        end
        exp_q.push_back(expected());
    endtask

    task automatic step(input bit t, input bit bm, input bit bi, input bit r);
        @(negedge clock);
        #1;
        tick_1hz = t; btn_mode = bm; btn_inc = bi; reset = r;
        if (r) begin
            #1;
            check("reset_async", got, 23'd0);
        end
        @(posedge clock);
        model(t, bm, bi, r);
    endtask

    task automatic press(input bit bm, input bit bi, input int tick_at);
        for (int i = 0; i < 14; i++) step(i == tick_at, i < 7 && bm, i < 7 && bi, 1'b0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); end
    endtask

    task automatic set_time(input int hh, input int mm);
        press(1'b1, 1'b0, -1);
        repeat ((hh - h + 24) % 24) press(1'b0, 1'b1, -1);
        press(1'b1, 1'b0, -1);
        repeat ((mm - m + 60) % 60) press(1'b0, 1'b1, -1);
        press(1'b1, 1'b0, -1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit rm, ri;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(60);
        set_time(23, 59);
        ticks(60);
        press(1'b1, 1'b0, -1);
        repeat (24) press(1'b0, 1'b1, -1);
        press(1'b1, 1'b0, -1);
        repeat (60) press(1'b0, 1'b1, -1);
        press(1'b1, 1'b0, -1);
        for (int i = 0; i < 20; i++) step(1'b0, (i / 2) % 2 == 0, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(3);
        press(1'b1, 1'b0, -1);
        press(1'b1, 1'b0, -1);
        press(1'b1, 1'b1, -1);
        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, -1);
        press(1'b0, 1'b1, 6);
        press(1'b1, 1'b0, 6);
        press(1'b1, 1'b0, 6);
        press(1'b1, 1'b0, -1);
        press(1'b1, 1'b0, -1);
        set_time(12, 34);
        ticks(10);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0);
        rm = 0; ri = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) rm = ~rm;
            if ($urandom_range(5) == 0) ri = ~ri;
            step($urandom_range(3) == 0, rm, ri, $urandom_range(599) == 0);
        end
        @(negedge clock);
        #2;
        check("queue_drained", 23'(exp_q.size()), 23'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clock_time_setter.md
Name: clock_time_setter

Overview:
- Timekeeping and time-set front end for the Nexys-2 digital clock; sits directly upstream of the ssd_driver/digit-multiplex stage.
- Keeps HH:MM:SS in a 24-hour format, advancing on a 1 Hz enable pulse.
- Debounces two push-buttons, MODE and INC, which drive a set-hours/set-minutes state machine.
- Outputs four BCD digits, a per-digit blink-blank mask and a seconds indicator, all ready for the display stage.

Parameters:
- DEBOUNCE_CYCLES, 500_000: consecutive stable samples needed to accept a button level change (10 ms at 50 MHz).
- DEB_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clock  input  1  system clock, 50 MHz
- reset  input  1  reset, asynchronous, active-high
- tick_1hz  input  1  one-cycle enable pulse, once per second, synchronous to clock
- btn_mode  input  1  raw MODE push-button, asynchronous, active-high
- btn_inc  input  1  raw INC push-button, asynchronous, active-high
- seg3  output  4  BCD hour tens (0-2)
- seg2  output  4  BCD hour ones (0-9)
- seg1  output  4  BCD minute tens (0-5)
- seg0  output  4  BCD minute ones (0-9)
- blank  output  4  bit i = 1 means digit i is to be blanked
- sec_odd  output  1  LSB of the seconds count, for the colon/dp LED
- mode  output  2  00 = RUN, 01 = SET_HOUR, 10 = SET_MIN

Behaviour:
- Reset (async, all registers):
  - time = 00:00:00; mode = RUN.
  - blank = 0000; sec_odd = 0; blink phase = 0.
  - Synchroniser flops, debounced levels and debounce counters = 0.
  - All outputs are registered.
- Debounce, per button:
  - 2-flop synchroniser.
  - Counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Press pulse = one cycle, asserted in the cycle the debounced level rises 0->1. Release produces no pulse.
  - A button held through reset release produces exactly one press after DEBOUNCE_CYCLES+2 cycles.
- Seconds:
  - Internal 6-bit binary counter, 0..59.
  - In RUN only, each tick_1hz increments it; 59 wraps to 0 with a carry to minutes.
- Minutes and hours:
  - Minutes are BCD 00..59; carry at 59 -> 00 increments hours.
  - Hours are BCD 00..23; 23 -> 00.
  - Full rollover: 23:59:59 + tick = 00:00:00.
- FSM transitions (evaluated on mode_press):
  - RUN -> SET_HOUR: seconds frozen.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> RUN: seconds counter cleared to 0 on that edge.
  - Every state entry clears blink phase to 0.
- SET_HOUR:
  - inc_press: hours +1, 23 -> 00; minutes unaffected.
  - tick_1hz toggles blink phase; the time does not advance.
- SET_MIN:
  - inc_press: minutes +1, 59 -> 00, with NO carry into hours.
  - tick_1hz toggles blink phase.
- Blank mask:
  - RUN: 0000.
  - SET_HOUR: 1100 when blink phase = 1, else 0000.
  - SET_MIN: 0011 when blink phase = 1, else 0000.
- Latency:
  - Outputs reflect a press or tick on the clock edge following the pulse cycle.
  - Digits never show non-BCD codes.
- Simultaneous events:
  - mode_press + inc_press in one cycle: mode wins, inc is discarded.
  - RUN with tick + mode_press: the tick advances time AND the state moves to SET_HOUR in the same edge.
  - SET state with tick + inc_press: the increment applies AND blink phase toggles.
- Reset mid-operation, any state or a partial debounce count: immediate return to the reset values above.

Test Plan:
- Reset, then 60 ticks in RUN: seg = 0,0,0,1 (00:01); sec_odd toggles every tick; blank = 0000 throughout.
- Preload 23:59:59 (via set mode plus 59 ticks), then one tick: digits 0,0,0,0; mode = 00.
- DEBOUNCE_CYCLES = 4. Bounce btn_mode 1/0 every 2 cycles for 20 cycles: no state change. Then hold it high for 8 cycles: exactly one transition to 01, occurring 2+4+1 cycles after the stable edge.
- SET_HOUR at 23:xx, one INC press: hours 00. Move to SET_MIN at 59, one INC press: minutes 00 and hours still 00. MODE press back to RUN: seconds = 0 and mode = 00.
- In SET_HOUR, three ticks: blank sequence 1100, 0000, 1100. A MODE press then clears blink phase, so blank = 0000 and mode = 10.
- In RUN at 12:34:10, assert reset for 1 cycle mid-debounce of a held INC: all outputs at reset values immediately. After release, one INC press is seen after DEBOUNCE_CYCLES+2 cycles; in RUN it has no effect on the time.
